// File: rtl/forward_select_gen_if.sv
// rtl/forward_select_gen_if.sv - ID-stage instruction fields in, EX operand selects and stall out.
interface forward_select_gen_if #(
   parameter int REG_ADDR_W = 5
);
   logic [REG_ADDR_W-1:0] ID_Rs;
   logic [REG_ADDR_W-1:0] ID_Rt;
   logic                  ID_UsesRs;
   logic                  ID_UsesRt;
   logic                  ID_RegWrite;
   logic                  ID_MemRead;
   logic [REG_ADDR_W-1:0] ID_WriteReg;
   logic                  Flush;
   logic [1:0]            ForwardA;
   logic [1:0]            ForwardB;
   logic                  Stall;

   modport master (
      output ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_RegWrite, ID_MemRead, ID_WriteReg, Flush,
      input  ForwardA, ForwardB, Stall
   );

   modport slave (
      input  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_RegWrite, ID_MemRead, ID_WriteReg, Flush,
      output ForwardA, ForwardB, Stall
   );
endinterface

// File: rtl/forward_select_gen.sv
// rtl/forward_select_gen.sv - forwarding selects and load-use stall from a shadow EX/MEM/WB pipeline.
module forward_select_gen #(
   parameter int REG_ADDR_W = 5,
   parameter int ZERO_REG   = 0
) (
   input logic                   Clk,
   input logic                   Reset,
   forward_select_gen_if.slave   bus
);
   localparam logic [REG_ADDR_W-1:0] zero_reg = REG_ADDR_W'(ZERO_REG);

   localparam logic [1:0] sel_regfile = 2'b00;
   localparam logic [1:0] sel_wb      = 2'b01;
   localparam logic [1:0] sel_mem     = 2'b10;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rs;
      logic [REG_ADDR_W-1:0] rt;
      logic                  uses_rs;
      logic                  uses_rt;
      logic                  reg_write;
      logic                  mem_read;
      logic [REG_ADDR_W-1:0] write_reg;
   } slot_t;

   slot_t id_slot;
   slot_t ex_slot;
   slot_t mem_slot;
   slot_t wb_slot;

   logic       ex_is_load;
   logic       stall;
   logic [1:0] fwd_a;
   logic [1:0] fwd_b;

   // A slot can only feed an operand if it really writes a non-zero register.
   function automatic logic writes_reg(input slot_t s, input logic [REG_ADDR_W-1:0] r);
      return s.valid && s.reg_write && (s.write_reg != zero_reg) && (s.write_reg == r);
   endfunction

   function automatic logic [1:0] select_for(input slot_t ex, input slot_t mem, input slot_t wb,
                                             input logic uses, input logic [REG_ADDR_W-1:0] r);
      if (!ex.valid || !uses) begin
         return sel_regfile;
      end else if (writes_reg(mem, r)) begin
         return sel_mem;
      end else if (writes_reg(wb, r)) begin
         return sel_wb;
      end
      return sel_regfile;
   endfunction

   always_comb begin
      id_slot           = '0;
      id_slot.valid     = 1'b1;
      id_slot.rs        = bus.ID_Rs;
      id_slot.rt        = bus.ID_Rt;
      id_slot.uses_rs   = bus.ID_UsesRs;
      id_slot.uses_rt   = bus.ID_UsesRt;
      id_slot.reg_write = bus.ID_RegWrite;
      id_slot.mem_read  = bus.ID_MemRead;
      id_slot.write_reg = bus.ID_WriteReg;
   end

   always_comb begin
      fwd_a = select_for(ex_slot, mem_slot, wb_slot, ex_slot.uses_rs, ex_slot.rs);
      fwd_b = select_for(ex_slot, mem_slot, wb_slot, ex_slot.uses_rt, ex_slot.rt);
   end

   // Only a load still in EX is too late to forward from; one bubble moves it to MEM.
   always_comb begin
      ex_is_load = ex_slot.valid && ex_slot.mem_read && ex_slot.reg_write &&
                   (ex_slot.write_reg != zero_reg);
      stall      = ex_is_load &&
                   ((bus.ID_UsesRs && (bus.ID_Rs == ex_slot.write_reg)) ||
                    (bus.ID_UsesRt && (bus.ID_Rt == ex_slot.write_reg)));
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         ex_slot  <= '0;
         mem_slot <= '0;
         wb_slot  <= '0;
      end else begin
         wb_slot  <= mem_slot;
         mem_slot <= ex_slot;
         if (stall || bus.Flush) begin
            ex_slot <= '0;
         end else begin
            ex_slot <= id_slot;
         end
      end
   end

   assign bus.ForwardA = fwd_a;
   assign bus.ForwardB = fwd_b;
   assign bus.Stall    = stall;

   logic unused_slot_bits;
   assign unused_slot_bits = ^{mem_slot.rs, mem_slot.rt, mem_slot.uses_rs, mem_slot.uses_rt,
                               mem_slot.mem_read, wb_slot.rs, wb_slot.rt, wb_slot.uses_rs,
                               wb_slot.uses_rt, wb_slot.mem_read};
endmodule

// File: tb/tb_forward_select_gen.sv
// tb/tb_forward_select_gen.sv - directed instruction sequences plus random stream vs a queue model.
module tb_forward_select_gen;
   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   forward_select_gen_if #(.REG_ADDR_W(5)) bus ();

   forward_select_gen #(.REG_ADDR_W(5), .ZERO_REG(0)) dut (
      .Clk   (clk),
      .Reset (reset),
      .bus   (bus.slave)
   );

   typedef struct packed {
      logic       v;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       urs;
      logic       urt;
      logic       rw;
      logic       mr;
      logic [4:0] wr;
   } ins_t;

   typedef struct packed {
      ins_t       ins;
      logic       flush;
      logic       rst;
      logic [1:0] fa;
      logic [1:0] fb;
      logic       st;
   } vec_t;

   int n_vec = 0;
   int n_bad = 0;

   // In-flight instructions, newest first: index 0 is EX, 1 is MEM, 2 is WB.
   ins_t q[$];

   function automatic ins_t mk(int rs, int rt, bit urs, bit urt, bit rw, bit mr, int wr);
      ins_t i;
      i.v = 1'b1; i.rs = 5'(rs); i.rt = 5'(rt); i.urs = urs; i.urt = urt;
      i.rw = rw; i.mr = mr; i.wr = 5'(wr);
      return i;
   endfunction

   function automatic vec_t mkv(ins_t i, bit fl, bit rs, int fa, int fb, bit st);
      vec_t v;
      v.ins = i; v.flush = fl; v.rst = rs; v.fa = 2'(fa); v.fb = 2'(fb); v.st = st;
      return v;
   endfunction

   function automatic ins_t slot(int k);
      ins_t empty = '0;
      if (k < q.size()) return q[k];
      return empty;
   endfunction

   function automatic logic [1:0] m_fwd(bit use_rt);
      ins_t e = slot(0);
      int   r = use_rt ? int'(e.rt) : int'(e.rs);
      bit   u = use_rt ? e.urt : e.urs;
      if (!e.v || !u) return 2'b00;
      for (int k = 1; k <= 2; k++) begin
         ins_t p = slot(k);
         if (p.v && p.rw && p.wr != 0 && int'(p.wr) == r) return (k == 1) ? 2'b10 : 2'b01;
      end
      return 2'b00;
   endfunction

   function automatic bit m_stall(ins_t id);
      ins_t e = slot(0);
      if (!(e.v && e.mr && e.rw && e.wr != 0)) return 1'b0;
      return (id.urs && id.rs == e.wr) || (id.urt && id.rt == e.wr);
   endfunction

   function automatic void m_advance(ins_t id, bit fl, bit rst, bit st);
      ins_t n = id;
      if (rst) begin
         q.delete();
      end else begin
         if (st || fl) n = '0;
         else n.v = 1'b1;
         q.push_front(n);
         if (q.size() > 3) void'(q.pop_back());
      end
   endfunction

   task automatic drive(input ins_t i, input logic fl, input logic rs);
      bus.ID_Rs       = i.rs;
      bus.ID_Rt       = i.rt;
      bus.ID_UsesRs   = i.urs;
      bus.ID_UsesRt   = i.urt;
      bus.ID_RegWrite = i.rw;
      bus.ID_MemRead  = i.mr;
      bus.ID_WriteReg = i.wr;
      bus.Flush       = fl;
      reset           = rs;
   endtask

   task automatic chk(input string name, input int idx, input logic [1:0] act, input logic [1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s #%0d: got %b expected %b", name, idx, act, exp);
      end
   endtask

   task automatic step(input ins_t i, input logic fl, input logic rs, input bit st);
      @(posedge clk);
      m_advance(i, fl, rs, st);
      @(negedge clk);
   endtask

   vec_t vecs[$];
   ins_t nop;
   ins_t cur;
   bit   fl, rs, st, hold;

   initial begin
      nop = mk(0, 0, 0, 0, 0, 0, 0);

      // add/sub back-to-back; add, nop, or; double producer of $3; load-use on Rs.
      vecs.push_back(mkv(mk(2, 3, 1, 1, 1, 0, 1),   0, 0, 0, 0, 0));
      vecs.push_back(mkv(mk(1, 5, 1, 1, 1, 0, 4),   0, 0, 0, 0, 0));
      vecs.push_back(mkv(nop,                      0, 0, 2, 0, 0));
      vecs.push_back(mkv(mk(2, 3, 1, 1, 1, 0, 1),   0, 0, 0, 0, 0));
      vecs.push_back(mkv(nop,                      0, 0, 0, 0, 0));
      vecs.push_back(mkv(mk(7, 1, 1, 1, 1, 0, 6),   0, 0, 0, 0, 0));
      vecs.push_back(mkv(nop,                      0, 0, 0, 1, 0));
      vecs.push_back(mkv(mk(1, 2, 1, 1, 1, 0, 3),   0, 0, 0, 0, 0));
      vecs.push_back(mkv(mk(4, 5, 1, 1, 1, 0, 3),   0, 0, 0, 0, 0));
      vecs.push_back(mkv(mk(3, 3, 1, 1, 1, 0, 8),   0, 0, 0, 0, 0));
      vecs.push_back(mkv(nop,                      0, 0, 2, 2, 0));
      vecs.push_back(mkv(mk(9, 0, 1, 0, 1, 1, 2),   0, 0, 0, 0, 0));
      vecs.push_back(mkv(mk(2, 11, 1, 1, 1, 0, 10), 0, 0, 0, 0, 1));
      vecs.push_back(mkv(mk(2, 11, 1, 1, 1, 0, 10), 0, 0, 0, 0, 0));
      vecs.push_back(mkv(nop,                      0, 0, 1, 0, 0));
      // writes to $0 never forward; load of $0 never stalls
      vecs.push_back(mkv(mk(1, 2, 1, 1, 1, 0, 0),   0, 0, 0, 0, 0));
      vecs.push_back(mkv(mk(0, 0, 1, 1, 1, 0, 3),   0, 0, 0, 0, 0));
      vecs.push_back(mkv(nop,                      0, 0, 0, 0, 0));
      vecs.push_back(mkv(mk(9, 0, 1, 0, 1, 1, 0),   0, 0, 0, 0, 0));
      vecs.push_back(mkv(mk(0, 0, 1, 1, 1, 0, 5),   0, 0, 0, 0, 0));
      vecs.push_back(mkv(nop,                      0, 0, 0, 0, 0));
      // load-use in flight, then a one-cycle reset discards everything
      vecs.push_back(mkv(mk(9, 0, 1, 0, 1, 1, 2),   0, 0, 0, 0, 0));
      vecs.push_back(mkv(mk(2, 2, 1, 1, 1, 0, 10),  0, 0, 0, 0, 1));
      vecs.push_back(mkv(mk(2, 2, 1, 1, 1, 0, 10),  0, 0, 0, 0, 0));
      vecs.push_back(mkv(nop,                      0, 1, 1, 1, 0));
      vecs.push_back(mkv(mk(2, 2, 1, 1, 1, 0, 7),   0, 0, 0, 0, 0));
      vecs.push_back(mkv(nop,                      0, 0, 0, 0, 0));
      // flushed producer must not forward
      vecs.push_back(mkv(mk(1, 1, 1, 1, 1, 0, 9),   1, 0, 0, 0, 0));
      vecs.push_back(mkv(mk(9, 9, 1, 1, 1, 0, 4),   0, 0, 0, 0, 0));
      vecs.push_back(mkv(nop,                      0, 0, 0, 0, 0));
      // flush together with a load-use stall
      vecs.push_back(mkv(mk(9, 0, 1, 0, 1, 1, 2),   0, 0, 0, 0, 0));
      vecs.push_back(mkv(mk(2, 2, 1, 1, 1, 0, 10),  1, 0, 0, 0, 1));
      vecs.push_back(mkv(nop,                      0, 0, 0, 0, 0));
      vecs.push_back(mkv(nop,                      0, 0, 0, 0, 0));
      // load-use on Rt
      vecs.push_back(mkv(mk(9, 0, 1, 0, 1, 1, 3),   0, 0, 0, 0, 0));
      vecs.push_back(mkv(mk(5, 3, 1, 1, 1, 0, 1),   0, 0, 0, 0, 1));
      vecs.push_back(mkv(mk(5, 3, 1, 1, 1, 0, 1),   0, 0, 0, 0, 0));
      vecs.push_back(mkv(nop,                      0, 0, 0, 1, 0));

      drive(nop, 1'b0, 1'b1);
      @(negedge clk);
      step(nop, 1'b0, 1'b1, 1'b0);
      step(nop, 1'b0, 1'b1, 1'b0);

      foreach (vecs[i]) begin
         drive(vecs[i].ins, vecs[i].flush, vecs[i].rst);
         #1;
         chk("dir_forward_a", i, bus.ForwardA, vecs[i].fa);
         chk("dir_forward_b", i, bus.ForwardB, vecs[i].fb);
         chk("dir_stall",     i, {1'b0, bus.Stall}, {1'b0, vecs[i].st});
         step(vecs[i].ins, vecs[i].flush, vecs[i].rst, m_stall(vecs[i].ins));
      end

      hold = 1'b0;
      cur  = nop;
      for (int n = 0; n < 3000; n++) begin
         if (!hold) begin
            cur = mk($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                     ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                     $urandom_range(0, 3));
         end
         fl = ($urandom_range(0, 9) == 0);
         rs = ($urandom_range(0, 99) == 0);
         drive(cur, fl, rs);
         #1;
         st = m_stall(cur);
         chk("rnd_forward_a", n, bus.ForwardA, m_fwd(1'b0));
         chk("rnd_forward_b", n, bus.ForwardB, m_fwd(1'b1));
         chk("rnd_stall",     n, {1'b0, bus.Stall}, {1'b0, st});
         hold = st && !fl && !rs;
         step(cur, fl, rs, st);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
